// File: rtl/rds_group_decoder.sv
// rtl/rds_group_decoder.sv - RDS block sync, group assembly, PI and PS name extraction
module rds_group_decoder #(
  parameter int BAD_LIMIT  = 8,
  parameter int PI_CONFIRM = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        rds_bit,
  input  logic        rds_bit_vld,
  output logic        blk_vld,
  output logic [15:0] blk_data,
  output logic [2:0]  blk_id,
  output logic        grp_vld,
  output logic [63:0] grp_data,
  output logic        synced,
  output logic [15:0] pi_code,
  output logic [63:0] ps_name,
  output logic        ps_vld
);
  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  localparam logic [3:0] BAD_LIM = 4'(BAD_LIMIT);
  localparam logic [1:0] PI_CONF = 2'(PI_CONFIRM);
  localparam logic [9:0] G_TAPS  = 10'h1B9;

  function automatic logic [9:0] crc10(input logic [15:0] m);
    logic [9:0] c;
    logic       fb;
    c = '0;
    for (int i = 15; i >= 0; i--) begin
      fb = m[i] ^ c[9];
      c  = {c[8:0], 1'b0};
      if (fb) c = c ^ G_TAPS;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [25:0] sr_q, sr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  slot_q, slot_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic [1:0]  grp_stage_q, grp_stage_d;
  logic [15:0] grp_a_q, grp_a_d, grp_b_q, grp_b_d, grp_c_q, grp_c_d;
  logic [15:0] pi_last_q, pi_last_d;
  logic [1:0]  pi_run_q, pi_run_d;
  logic        pi_ok_q, pi_ok_d;
  logic [3:0]  seg_mask_q, seg_mask_d;
  logic        blk_vld_q, blk_vld_d;
  logic [15:0] blk_data_q, blk_data_d;
  logic [2:0]  blk_id_q, blk_id_d;
  logic        grp_vld_q, grp_vld_d;
  logic [63:0] grp_data_q, grp_data_d;
  logic        synced_q, synced_d;
  logic [15:0] pi_code_q, pi_code_d;
  logic [63:0] ps_name_q, ps_name_d;
  logic        ps_vld_q, ps_vld_d;

  logic [9:0]  ofs;
  logic        ofs_ok;
  logic [2:0]  ofs_id;
  logic [1:0]  ofs_slot;
  logic        good;
  logic [1:0]  nxt_slot;
  logic [1:0]  pi_run_nx;
  logic [3:0]  seg_mask_nx;
  logic [15:0] word;

  assign sr_d = rds_bit_vld ? {sr_q[24:0], rds_bit} : sr_q;
  assign word = sr_d[25:10];

  // Syndrome of the freshly shifted window; C and C' share slot 2.
  always_comb begin
    ofs      = sr_d[9:0] ^ crc10(word);
    ofs_ok   = 1'b1;
    ofs_id   = 3'd0;
    ofs_slot = 2'd0;
    case (ofs)
      10'h0FC: begin ofs_id = 3'd0; ofs_slot = 2'd0; end
      10'h198: begin ofs_id = 3'd1; ofs_slot = 2'd1; end
      10'h168: begin ofs_id = 3'd2; ofs_slot = 2'd2; end
      10'h350: begin ofs_id = 3'd3; ofs_slot = 2'd2; end
      10'h1B4: begin ofs_id = 3'd4; ofs_slot = 2'd3; end
      default: ofs_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    slot_d      = slot_q;
    bad_cnt_d   = bad_cnt_q;
    grp_stage_d = grp_stage_q;
    grp_a_d     = grp_a_q;
    grp_b_d     = grp_b_q;
    grp_c_d     = grp_c_q;
    pi_last_d   = pi_last_q;
    pi_run_d    = pi_run_q;
    pi_ok_d     = pi_ok_q;
    seg_mask_d  = seg_mask_q;
    blk_vld_d   = 1'b0;
    blk_data_d  = blk_data_q;
    blk_id_d    = blk_id_q;
    grp_vld_d   = 1'b0;
    grp_data_d  = grp_data_q;
    synced_d    = synced_q;
    pi_code_d   = pi_code_q;
    ps_name_d   = ps_name_q;
    ps_vld_d    = ps_vld_q;
    good        = 1'b0;
    nxt_slot    = slot_q + 2'd1;
    pi_run_nx   = 2'd1;
    seg_mask_nx = seg_mask_q;

    if (rds_bit_vld) begin
      case (state_q)
        SEARCH: begin
          if (ofs_ok) begin
            slot_d    = ofs_slot;
            bit_cnt_d = '0;
            state_d   = CONFIRM;
          end
        end
        CONFIRM: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd25) begin
            bit_cnt_d = '0;
            if (ofs_ok && ofs_slot == nxt_slot) begin
              state_d     = LOCKED;
              synced_d    = 1'b1;
              slot_d      = nxt_slot;
              bad_cnt_d   = '0;
              grp_stage_d = 2'd0;
              good        = 1'b1;
            end else begin
              state_d = SEARCH;
            end
          end
        end
        LOCKED: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd25) begin
            bit_cnt_d = '0;
            slot_d    = nxt_slot;
            if (ofs_ok && ofs_slot == nxt_slot) begin
              good      = 1'b1;
              bad_cnt_d = '0;
            end else begin
              // Flywheel: the slot keeps advancing, the group is abandoned.
              grp_stage_d = 2'd0;
              bad_cnt_d   = bad_cnt_q + 4'd1;
              if (bad_cnt_q + 4'd1 == BAD_LIM) begin
                state_d    = SEARCH;
                synced_d   = 1'b0;
                ps_vld_d   = 1'b0;
                seg_mask_d = '0;
                bad_cnt_d  = '0;
              end
            end
          end
        end
        default: state_d = SEARCH;
      endcase

      if (good) begin
        blk_vld_d  = 1'b1;
        blk_data_d = word;
        blk_id_d   = ofs_id;
        case (nxt_slot)
          2'd0: begin
            grp_a_d     = word;
            grp_stage_d = 2'd1;
            if (pi_run_q != 2'd0 && word == pi_last_q)
              pi_run_nx = (pi_run_q >= PI_CONF) ? pi_run_q : pi_run_q + 2'd1;
            pi_run_d  = pi_run_nx;
            pi_last_d = word;
            if (pi_run_nx >= PI_CONF) begin
              if (!pi_ok_q || word != pi_code_q) begin
                ps_name_d  = '0;
                seg_mask_d = '0;
                ps_vld_d   = 1'b0;
              end
              pi_code_d = word;
              pi_ok_d   = 1'b1;
            end
          end
          2'd1: begin
            grp_b_d     = word;
            grp_stage_d = (grp_stage_q == 2'd1) ? 2'd2 : 2'd0;
          end
          2'd2: begin
            grp_c_d     = word;
            grp_stage_d = (grp_stage_q == 2'd2) ? 2'd3 : 2'd0;
          end
          default: begin
            grp_stage_d = 2'd0;
            if (grp_stage_q == 2'd3) begin
              grp_vld_d  = 1'b1;
              grp_data_d = {grp_a_q, grp_b_q, grp_c_q, word};
              if (grp_b_q[15:12] == 4'd0 && pi_ok_q && grp_a_q == pi_code_q) begin
                case (grp_b_q[1:0])
                  2'd0:    ps_name_d[63:48] = word;
                  2'd1:    ps_name_d[47:32] = word;
                  2'd2:    ps_name_d[31:16] = word;
                  default: ps_name_d[15:0]  = word;
                endcase
                seg_mask_nx = seg_mask_q | (4'b0001 << grp_b_q[1:0]);
                seg_mask_d  = seg_mask_nx;
                ps_vld_d    = &seg_mask_nx;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      slot_q      <= '0;
      bad_cnt_q   <= '0;
      grp_stage_q <= '0;
      grp_a_q     <= '0;
      grp_b_q     <= '0;
      grp_c_q     <= '0;
      pi_last_q   <= '0;
      pi_run_q    <= '0;
      pi_ok_q     <= 1'b0;
      seg_mask_q  <= '0;
      blk_vld_q   <= 1'b0;
      blk_data_q  <= '0;
      blk_id_q    <= '0;
      grp_vld_q   <= 1'b0;
      grp_data_q  <= '0;
      synced_q    <= 1'b0;
      pi_code_q   <= '0;
      ps_name_q   <= '0;
      ps_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_q      <= slot_d;
      bad_cnt_q   <= bad_cnt_d;
      grp_stage_q <= grp_stage_d;
      grp_a_q     <= grp_a_d;
      grp_b_q     <= grp_b_d;
      grp_c_q     <= grp_c_d;
      pi_last_q   <= pi_last_d;
      pi_run_q    <= pi_run_d;
      pi_ok_q     <= pi_ok_d;
      seg_mask_q  <= seg_mask_d;
      blk_vld_q   <= blk_vld_d;
      blk_data_q  <= blk_data_d;
      blk_id_q    <= blk_id_d;
      grp_vld_q   <= grp_vld_d;
      grp_data_q  <= grp_data_d;
      synced_q    <= synced_d;
      pi_code_q   <= pi_code_d;
      ps_name_q   <= ps_name_d;
      ps_vld_q    <= ps_vld_d;
    end
  end

  assign blk_vld  = blk_vld_q;
  assign blk_data = blk_data_q;
  assign blk_id   = blk_id_q;
  assign grp_vld  = grp_vld_q;
  assign grp_data = grp_data_q;
  assign synced   = synced_q;
  assign pi_code  = pi_code_q;
  assign ps_name  = ps_name_q;
  assign ps_vld   = ps_vld_q;
endmodule

// File: tb/tb_rds_group_decoder.sv
// tb/tb_rds_group_decoder.sv - scoreboard bench for rds_group_decoder with a polynomial-division reference model
module tb_rds_group_decoder;
  localparam int BAD_LIMIT  = 8;
  localparam int PI_CONFIRM = 2;

  logic        clk;
  logic        arst_n;
  logic        rds_bit;
  logic        rds_bit_vld;
  logic        blk_vld;
  logic [15:0] blk_data;
  logic [2:0]  blk_id;
  logic        grp_vld;
  logic [63:0] grp_data;
  logic        synced;
  logic [15:0] pi_code;
  logic [63:0] ps_name;
  logic        ps_vld;

  rds_group_decoder #(.BAD_LIMIT(BAD_LIMIT), .PI_CONFIRM(PI_CONFIRM)) dut (
    .clk(clk), .arst_n(arst_n), .rds_bit(rds_bit), .rds_bit_vld(rds_bit_vld),
    .blk_vld(blk_vld), .blk_data(blk_data), .blk_id(blk_id),
    .grp_vld(grp_vld), .grp_data(grp_data), .synced(synced),
    .pi_code(pi_code), .ps_name(ps_name), .ps_vld(ps_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          blk;
    logic [15:0] bdata;
    logic [2:0]  bid;
    bit          grp;
    logic [63:0] gdata;
    bit          sync;
    logic [15:0] pi;
    logic [63:0] ps;
    bit          psv;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   grp_seen = 0;
  int   max_gap = 5;
  int   grp_idx = 0;
  bit   pend = 0;

  // Reference model state, kept in specification terms.
  int          m_state;
  logic [25:0] m_win;
  int          m_cnt, m_slot, m_bad;
  logic [15:0] m_words[$];
  logic [15:0] m_pi_last, m_pi;
  int          m_pi_run;
  bit          m_pi_ok, m_sync;
  bit          m_have[4];
  logic [7:0]  m_ps[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] mod_g(input logic [25:0] w);
    logic [25:0] r;
    r = w;
    for (int i = 25; i >= 10; i--)
      if (r[i]) r = r ^ (26'h5B9 << (i - 10));
    return r[9:0];
  endfunction

  function automatic logic [25:0] enc(input logic [15:0] d, input logic [9:0] o);
    return {d, mod_g({d, 10'b0}) ^ o};
  endfunction

  function automatic int ofs_to_id(input logic [9:0] s);
    case (s)
      10'h0FC: return 0;
      10'h198: return 1;
      10'h168: return 2;
      10'h350: return 3;
      10'h1B4: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int slot_of(input int id);
    return (id >= 3) ? id - 1 : id;
  endfunction

  function automatic logic [15:0] ps_word(input int seg);
    logic [63:0] s;
    s = "TEST1234";
    return s[63 - 16*seg -: 16];
  endfunction

  task automatic clear_ps_mask();
    for (int k = 0; k < 4; k++) m_have[k] = 0;
  endtask

  task automatic model_reset();
    m_state = 0; m_win = '0; m_cnt = 0; m_slot = 0; m_bad = 0;
    m_words.delete();
    m_pi_last = '0; m_pi = '0; m_pi_run = 0; m_pi_ok = 0; m_sync = 0;
    clear_ps_mask();
    for (int k = 0; k < 8; k++) m_ps[k] = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic b);
    exp_t e;
    int id;
    bit good;
    logic [15:0] w;
    m_win = {m_win[24:0], b};
    id = ofs_to_id(mod_g(m_win));
    w = m_win[25:10];
    e.blk = 0; e.bdata = '0; e.bid = '0; e.grp = 0; e.gdata = '0;
    good = 0;
    if (m_state == 0) begin
      if (id >= 0) begin m_slot = slot_of(id); m_cnt = 0; m_state = 1; end
    end else begin
      m_cnt++;
      if (m_cnt == 26) begin
        m_cnt = 0;
        m_slot = (m_slot + 1) % 4;
        if (id >= 0 && slot_of(id) == m_slot) begin
          good = 1; m_bad = 0;
          if (m_state == 1) begin m_state = 2; m_sync = 1; m_words.delete(); end
        end else if (m_state == 1) begin
          m_state = 0;
        end else begin
          m_words.delete();
          m_bad++;
          if (m_bad == BAD_LIMIT) begin
            m_state = 0; m_sync = 0; m_bad = 0; clear_ps_mask();
          end
        end
      end
    end
    if (good) begin
      e.blk = 1; e.bdata = w; e.bid = id[2:0];
      if (m_slot == 0) begin
        m_words.delete();
        m_words.push_back(w);
        if (m_pi_run > 0 && w == m_pi_last) m_pi_run = (m_pi_run < PI_CONFIRM) ? m_pi_run + 1 : m_pi_run;
        else m_pi_run = 1;
        m_pi_last = w;
        if (m_pi_run >= PI_CONFIRM) begin
          if (!m_pi_ok || w != m_pi) begin
            clear_ps_mask();
            for (int k = 0; k < 8; k++) m_ps[k] = '0;
          end
          m_pi = w; m_pi_ok = 1;
        end
      end else if (m_words.size() == m_slot) begin
        m_words.push_back(w);
        if (m_slot == 3) begin
          e.grp = 1;
          e.gdata = {m_words[0], m_words[1], m_words[2], m_words[3]};
          if (m_words[1][15:12] == 4'd0 && m_pi_ok && m_words[0] == m_pi) begin
            m_ps[2*m_words[1][1:0]]     = w[15:8];
            m_ps[2*m_words[1][1:0] + 1] = w[7:0];
            m_have[m_words[1][1:0]]     = 1;
          end
          m_words.delete();
        end
      end else begin
        m_words.delete();
      end
    end
    e.sync = m_sync;
    e.pi   = m_pi;
    e.ps   = {m_ps[0], m_ps[1], m_ps[2], m_ps[3], m_ps[4], m_ps[5], m_ps[6], m_ps[7]};
    e.psv  = m_have[0] && m_have[1] && m_have[2] && m_have[3];
    exp_q.push_back(e);
  endtask

  always @(posedge clk) pend = rds_bit_vld && arst_n;

  always @(negedge clk) begin
    exp_t e;
    if (!arst_n) begin
      chk("rst_outputs", {blk_vld, grp_vld, synced, ps_vld, blk_id, blk_data, pi_code}, '0);
      chk("rst_grp_data", grp_data, '0);
      chk("rst_ps_name", ps_name, '0);
    end else if (pend) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("blk_vld", blk_vld, e.blk);
        if (e.blk) begin
          chk("blk_data", blk_data, e.bdata);
          chk("blk_id", blk_id, e.bid);
        end
        chk("grp_vld", grp_vld, e.grp);
        if (e.grp) chk("grp_data", grp_data, e.gdata);
        chk("synced", synced, e.sync);
        chk("pi_code", pi_code, e.pi);
        chk("ps_name", ps_name, e.ps);
        chk("ps_vld", ps_vld, e.psv);
      end
      if (grp_vld) grp_seen++;
    end else begin
      chk("idle_strobes", {blk_vld, grp_vld}, 2'b00);
    end
  end

  task automatic send_bit(input logic b);
    int gap;
    rds_bit = b;
    rds_bit_vld = 1'b1;
    @(posedge clk);
    model_step(b);
    #1;
    rds_bit_vld = 1'b0;
    gap = $urandom_range(0, max_gap);
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic send_word(input logic [25:0] w, input int nbits);
    for (int i = 25; i > 25 - nbits; i--) send_bit(w[i]);
  endtask

  // corrupt[k] flips one check bit of block k; cprime puts C' in slot 3.
  task automatic send_group(input logic [15:0] pi, input bit cprime, input logic [3:0] corrupt);
    logic [25:0] blk[4];
    int seg;
    seg = grp_idx % 4;
    grp_idx++;
    blk[0] = enc(pi, 10'h0FC);
    blk[1] = enc(16'h0400 | 16'(seg), 10'h198);
    blk[2] = enc(16'($urandom), cprime ? 10'h350 : 10'h168);
    blk[3] = enc(ps_word(seg), 10'h1B4);
    for (int k = 0; k < 4; k++) begin
      if (corrupt[k]) blk[k] = blk[k] ^ (26'd1 << $urandom_range(0, 9));
      send_word(blk[k], 26);
    end
  endtask

  task automatic at_negedge();
    @(negedge clk);
    #1;
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b1; rds_bit = 1'b0; rds_bit_vld = 1'b0;
    model_reset();
    #2 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;

    for (int i = 0; i < 7; i++) send_bit(1'($urandom));
    for (int g = 0; g < 10; g++) send_group(16'hCAFE, 0, 4'h0);
    at_negedge();
    chk("acq_synced", synced, 1'b1);
    chk("acq_pi", pi_code, 16'hCAFE);
    chk("acq_ps_name", ps_name, 64'h5445535431323334);
    chk("acq_ps_vld", ps_vld, 1'b1);
    chk("acq_grp_count_ge3", grp_seen >= 3, 1'b1);
    realign();

    send_group(16'hCAFE, 0, 4'b0100);
    send_group(16'hCAFE, 0, 4'h0);
    at_negedge();
    chk("flip_c_synced", synced, 1'b1);
    realign();

    send_group(16'hCAFE, 0, 4'hF);
    send_group(16'hCAFE, 0, 4'hF);
    at_negedge();
    chk("drop_synced", synced, 1'b0);
    chk("drop_ps_vld", ps_vld, 1'b0);
    chk("drop_pi_kept", pi_code, 16'hCAFE);
    realign();
    for (int g = 0; g < 8; g++) send_group(16'hCAFE, 0, 4'h0);
    at_negedge();
    chk("reacq_synced", synced, 1'b1);
    chk("reacq_ps_vld", ps_vld, 1'b1);
    realign();

    for (int g = 0; g < 3; g++) send_group(16'hCAFE, 1, 4'h0);

    send_group(16'hBEEF, 0, 4'h0);
    send_group(16'hBEEF, 0, 4'h0);
    at_negedge();
    chk("pi_change_code", pi_code, 16'hBEEF);
    chk("pi_change_ps_vld", ps_vld, 1'b0);
    realign();
    for (int g = 0; g < 5; g++) send_group(16'hBEEF, 0, 4'h0);
    at_negedge();
    chk("pi_change_refill", ps_vld, 1'b1);
    chk("pi_change_name", ps_name, 64'h5445535431323334);
    realign();

    send_word(enc(16'hCAFE, 10'h0FC), 13);
    @(negedge clk);
    #1 arst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    max_gap = 0;
    for (int g = 0; g < 8; g++) send_group(16'hCAFE, 0, 4'h0);
    at_negedge();
    chk("post_rst_synced", synced, 1'b1);
    chk("post_rst_pi", pi_code, 16'hCAFE);
    chk("post_rst_ps_vld", ps_vld, 1'b1);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rds_group_decoder.md
Name: rds_group_decoder

Overview:
- Receive side of the RDS path: consumes the demodulated, differentially-decoded RDS bitstream, MSB first, one bit per strobe.
- Acquires and keeps block synchronisation using the 10-bit checkword and offset words.
- Emits checked 16-bit blocks, assembles 4-block groups and extracts the PI code and the 8-character PS name from type 0A/0B groups.
- Sits after the RDS demodulator; feeds status registers and the loopback self-test against the on-chip RDS transmitter.

Parameters:
- BAD_LIMIT, 8: consecutive bad blocks in LOCKED before sync is dropped (1..15).
- PI_CONFIRM, 2: consecutive identical block-A PI values required before pi_code updates (1..3).

Ports:
- clk  in  1  system clock
- arst_n  in  1  reset, asynchronous, active-low
- rds_bit  in  1  received data bit
- rds_bit_vld  in  1  one-cycle strobe qualifying rds_bit
- blk_vld  out  1  one-cycle strobe: block checked OK
- blk_data  out  16  information word of the checked block
- blk_id  out  3  0=A, 1=B, 2=C, 3=C', 4=D
- grp_vld  out  1  one-cycle strobe: complete good group
- grp_data  out  64  {A,B,C|C',D} of the last good group
- synced  out  1  high in LOCKED
- pi_code  out  16  confirmed PI
- ps_name  out  64  PS characters 0..7, char0 in [63:56]
- ps_vld  out  1  level: all 4 PS segments received since the last sync/PI change

Behaviour:
- Reset: all outputs 0; state SEARCH; 26-bit shift register, counters and segment mask cleared. Reset mid-operation discards the partial block/group immediately.
- Each rds_bit_vld shifts rds_bit into sr[25:0] (LSB in). Nothing advances without a strobe. Strobes may be back-to-back.
- Check: m = sr[25:10], r = sr[9:0]. c(m) = (m·x^10) mod g(x), with g = x^10+x^8+x^7+x^5+x^4+x^3+1. ofs = r XOR c(m).
- ofs matches: A 0x0FC, B 0x198, C 0x168, C' 0x350, D 0x1B4; anything else is a bad block.
- Evaluation uses the register after the shift. Outputs update 1 clk after the strobe cycle.
- Expected offset sequence: A→B→(C or C')→D→A. C and C' are both accepted in the third slot.
- SEARCH:
  - Evaluated on every bit.
  - Any valid offset: record it, bit counter = 0, go to CONFIRM. No blk_vld.
- CONFIRM:
  - Evaluated when the bit counter reaches 26.
  - Next expected offset valid: go to LOCKED, synced=1, output this block.
  - Otherwise: go to SEARCH.
- LOCKED:
  - Evaluated every 26 bits.
  - Valid block: blk_vld=1 with blk_data/blk_id, bad counter cleared.
  - Bad block: no blk_vld, bad counter +1, expected slot still advances (flywheel).
  - Bad counter reaching BAD_LIMIT: go to SEARCH, synced=0, ps_vld=0, segment mask cleared. pi_code is kept.
- Group assembly:
  - Slot-A good block opens a group.
  - Slots B, C/C', D must each be good in sequence.
  - D good with all 4 good: grp_vld=1, same cycle as the D blk_vld.
  - Any bad slot abandons the group until the next A.
- PI:
  - A counter tracks identical consecutive good block-A values.
  - On reaching PI_CONFIRM, pi_code is loaded.
  - If the new value ≠ old: ps_name cleared, segment mask cleared, ps_vld=0.
- PS:
  - On grp_vld with B[15:12]=0 (0A or 0B) and A==pi_code (pi_code confirmed): seg=B[1:0].
  - Write D[15:8], D[7:0] to chars 2·seg, 2·seg+1; set mask bit seg.
  - ps_vld=1 once the mask is 4'hF.
  - Simultaneous PI change and PS write in the same cycle: the clear wins.
- rds_bit_vld during reset is ignored. No back-pressure: outputs are strobes, with no hold.

Test Plan:
- Golden model encodes 4 type-0A groups with PI=0xCAFE, B=0x0400|seg, PS="TEST1234". Stream after 7 random bits → synced=1 after the second valid block; 3 good groups in a row give grp_vld; pi_code=0xCAFE; ps_name=0x5445535431323334; ps_vld=1 after seg 3.
- Flip 1 bit in a C block while LOCKED → no blk_vld for that slot, no grp_vld for that group, the following D still has blk_id=4, synced stays 1.
- Stream 8 consecutive corrupted blocks → synced falls 1 clk after the 8th block end; ps_vld=0; pi_code remains 0xCAFE; clean stream reacquires.
- Substitute C' (offset 0x350) in slot 3 → blk_id=3, group accepted.
- Change PI to 0xBEEF for 2 groups → pi_code=0xBEEF, ps_name cleared, ps_vld=0 until 4 segments arrive again.
- Assert arst_n low mid-block then release → all outputs 0, state SEARCH. Gaps of 0–5 idle cycles between strobes give identical results.
